// File: rtl/pipeline_pkg.sv
// Shared constants for the MIPS front end: sequencer state codes,
// exception vector and boot PC.
package pipeline_pkg;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_EXC  = 2'd2;

    localparam logic [31:0] EXC_VEC_DFLT = 32'h8000_0180;
    localparam logic [31:0] BOOT_PC      = 32'h0040_0000;

    typedef enum logic [1:0] {
        S_RUN  = ST_RUN,
        S_PEND = ST_PEND,
        S_EXC  = ST_EXC
    } seq_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: a load in EX writing a register
// that the instruction in ID reads.
module load_use_detect (
    input  logic       mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       hazard
);

    assign hazard = mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection, IF/ID hold/flush, load-use bubbles, redirects
// that wait for instruction memory, and exception entry.
module pc_sequencer
    import pipeline_pkg::*;
#(
    parameter int             N       = 32,
    parameter logic [N-1:0]   EXC_VEC = N'(EXC_VEC_DFLT),
    parameter int             CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     PC_Current,
    input  logic             IMem_Ready,
    input  logic [4:0]       IF_ID_Rs,
    input  logic [4:0]       IF_ID_Rt,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_Rt,
    input  logic             ID_Branch_Taken,
    input  logic [N-1:0]     ID_Branch_Tgt,
    input  logic             ID_Jump,
    input  logic [N-1:0]     ID_Jump_Tgt,
    input  logic             Exception,
    output logic [N-1:0]     NewPC,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic [N-1:0]     EPC,
    output logic [CNT_W-1:0] Stall_Count
);

    seq_state_t   state, state_n;
    logic [N-1:0] pend_tgt, pend_n;
    logic [N-1:0] epc_n;
    logic [N-1:0] pc_plus4;
    logic [N-1:0] redir_tgt;
    logic         load_use;

    load_use_detect u_lud (
        .mem_read (ID_EX_MemRead),
        .ex_rt    (ID_EX_Rt),
        .id_rs    (IF_ID_Rs),
        .id_rt    (IF_ID_Rt),
        .hazard   (load_use)
    );

    assign pc_plus4  = PC_Current + N'(4);
    // Jump outranks a taken branch when both resolve together.
    assign redir_tgt = ID_Jump ? ID_Jump_Tgt : ID_Branch_Tgt;

    always_comb begin
        state_n      = state;
        pend_n       = pend_tgt;
        epc_n        = EPC;
        NewPC        = pc_plus4;
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        if (reset) begin
            NewPC       = PC_Current;
            PC_Write    = 1'b1;
            IF_ID_Write = 1'b1;
            state_n     = S_RUN;
        end else begin
            unique case (state)
                S_RUN: begin
                    if (Exception) begin
                        NewPC        = EXC_VEC;
                        IF_ID_Flush  = 1'b1;
                        ID_EX_Bubble = 1'b1;
                        epc_n        = PC_Current;
                        state_n      = S_EXC;
                    end else if (load_use) begin
                        PC_Write     = 1'b1;
                        IF_ID_Write  = 1'b1;
                        ID_EX_Bubble = 1'b1;
                    end else if (ID_Jump || ID_Branch_Taken) begin
                        IF_ID_Flush = 1'b1;
                        if (IMem_Ready) begin
                            NewPC = redir_tgt;
                        end else begin
                            PC_Write = 1'b1;
                            pend_n   = redir_tgt;
                            state_n  = S_PEND;
                        end
                    end else if (!IMem_Ready) begin
                        PC_Write    = 1'b1;
                        IF_ID_Flush = 1'b1;
                    end
                end
                S_PEND: begin
                    IF_ID_Flush = 1'b1;
                    if (Exception) begin
                        NewPC        = EXC_VEC;
                        ID_EX_Bubble = 1'b1;
                        epc_n        = PC_Current;
                        state_n      = S_EXC;
                    end else if (IMem_Ready) begin
                        NewPC   = pend_tgt;
                        state_n = S_RUN;
                    end else begin
                        PC_Write = 1'b1;
                    end
                end
                S_EXC: begin
                    IF_ID_Flush = 1'b1;
                    PC_Write    = !IMem_Ready;
                    state_n     = S_RUN;
                end
                default: state_n = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_RUN;
            pend_tgt    <= '0;
            EPC         <= '0;
            Stall_Count <= '0;
        end else begin
            state    <= state_n;
            pend_tgt <= pend_n;
            EPC      <= epc_n;
            if (PC_Write && !(&Stall_Count))
                Stall_Count <= Stall_Count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: hazards, redirects, pending
// redirects, exceptions, reset and counter saturation.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC_Current;
    logic        IMem_Ready;
    logic [4:0]  IF_ID_Rs, IF_ID_Rt;
    logic        ID_EX_MemRead;
    logic [4:0]  ID_EX_Rt;
    logic        ID_Branch_Taken;
    logic [31:0] ID_Branch_Tgt;
    logic        ID_Jump;
    logic [31:0] ID_Jump_Tgt;
    logic        Exception;
    logic [31:0] NewPC;
    logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble;
    logic [31:0] EPC;
    logic [15:0] Stall_Count;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .PC_Current      (PC_Current),
        .IMem_Ready      (IMem_Ready),
        .IF_ID_Rs        (IF_ID_Rs),
        .IF_ID_Rt        (IF_ID_Rt),
        .ID_EX_MemRead   (ID_EX_MemRead),
        .ID_EX_Rt        (ID_EX_Rt),
        .ID_Branch_Taken (ID_Branch_Taken),
        .ID_Branch_Tgt   (ID_Branch_Tgt),
        .ID_Jump         (ID_Jump),
        .ID_Jump_Tgt     (ID_Jump_Tgt),
        .Exception       (Exception),
        .NewPC           (NewPC),
        .PC_Write        (PC_Write),
        .IF_ID_Write     (IF_ID_Write),
        .IF_ID_Flush     (IF_ID_Flush),
        .ID_EX_Bubble    (ID_EX_Bubble),
        .EPC             (EPC),
        .Stall_Count     (Stall_Count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        PC_Current      = 32'h0040_0000;
        IMem_Ready      = 1'b1;
        IF_ID_Rs        = 5'd0;
        IF_ID_Rt        = 5'd0;
        ID_EX_MemRead   = 1'b0;
        ID_EX_Rt        = 5'd0;
        ID_Branch_Taken = 1'b0;
        ID_Branch_Tgt   = 32'h0;
        ID_Jump         = 1'b0;
        ID_Jump_Tgt     = 32'h0;
        Exception       = 1'b0;

        repeat (2) tick();
        #1;
        chk("rst_pcw", 32'(PC_Write), 32'd1);
        chk("rst_ifw", 32'(IF_ID_Write), 32'd1);
        chk("rst_flush", 32'(IF_ID_Flush), 32'd0);
        chk("rst_npc", NewPC, 32'h0040_0000);
        chk("rst_epc", EPC, 32'h0);
        chk("rst_cnt", 32'(Stall_Count), 32'd0);

        // normal sequential fetch
        tick(); reset = 1'b0; #1;
        chk("run_pcw", 32'(PC_Write), 32'd0);
        chk("run_npc", NewPC, 32'h0040_0004);
        chk("run_cnt", 32'(Stall_Count), 32'd0);

        // load-use beats a taken branch
        tick();
        ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd8; IF_ID_Rs = 5'd8;
        ID_Branch_Taken = 1'b1; ID_Branch_Tgt = 32'h0040_0200;
        #1;
        chk("lu_pcw", 32'(PC_Write), 32'd1);
        chk("lu_ifw", 32'(IF_ID_Write), 32'd1);
        chk("lu_bub", 32'(ID_EX_Bubble), 32'd1);
        chk("lu_flush", 32'(IF_ID_Flush), 32'd0);

        // rt=0 is never a hazard, so the branch goes through
        tick(); ID_EX_Rt = 5'd0; #1;
        chk("lu0_cnt", 32'(Stall_Count), 32'd1);
        chk("lu0_pcw", 32'(PC_Write), 32'd0);
        chk("lu0_bub", 32'(ID_EX_Bubble), 32'd0);
        chk("lu0_npc", NewPC, 32'h0040_0200);
        chk("lu0_flush", 32'(IF_ID_Flush), 32'd1);

        // jump wins over branch
        tick();
        ID_EX_MemRead = 1'b0; ID_Jump = 1'b1; ID_Jump_Tgt = 32'h0040_0100;
        #1;
        chk("jmp_npc", NewPC, 32'h0040_0100);
        chk("jmp_flush", 32'(IF_ID_Flush), 32'd1);
        chk("jmp_pcw", 32'(PC_Write), 32'd0);

        // branch while memory busy for three cycles
        tick();
        ID_Jump = 1'b0; ID_Branch_Tgt = 32'h0040_0040; IMem_Ready = 1'b0;
        #1;
        chk("pd0_pcw", 32'(PC_Write), 32'd1);
        chk("pd0_flush", 32'(IF_ID_Flush), 32'd1);
        tick(); ID_Branch_Taken = 1'b0; #1;
        chk("pd1_pcw", 32'(PC_Write), 32'd1);
        tick(); ID_Jump = 1'b1; ID_Jump_Tgt = 32'h0040_0300; #1;
        chk("pd2_pcw", 32'(PC_Write), 32'd1);
        chk("pd2_flush", 32'(IF_ID_Flush), 32'd1);
        tick(); ID_Jump = 1'b0; IMem_Ready = 1'b1; #1;
        chk("pd3_npc", NewPC, 32'h0040_0040);
        chk("pd3_pcw", 32'(PC_Write), 32'd0);
        chk("pd3_cnt", 32'(Stall_Count), 32'd4);

        // exception, then a second one masked in EXC
        tick(); PC_Current = 32'h0040_000C; Exception = 1'b1; #1;
        chk("ex_npc", NewPC, 32'h8000_0180);
        chk("ex_flush", 32'(IF_ID_Flush), 32'd1);
        chk("ex_bub", 32'(ID_EX_Bubble), 32'd1);
        chk("ex_pcw", 32'(PC_Write), 32'd0);
        tick(); PC_Current = 32'h8000_0180; #1;
        chk("exc_epc", EPC, 32'h0040_000C);
        chk("exc_npc", NewPC, 32'h8000_0184);
        chk("exc_flush", 32'(IF_ID_Flush), 32'd1);
        chk("exc_bub", 32'(ID_EX_Bubble), 32'd0);
        tick(); Exception = 1'b0; PC_Current = 32'h8000_0184; #1;
        chk("back_flush", 32'(IF_ID_Flush), 32'd0);
        chk("back_npc", NewPC, 32'h8000_0188);
        chk("back_pcw", 32'(PC_Write), 32'd0);

        // reset pulsed while a redirect is pending
        tick();
        IMem_Ready = 1'b0; ID_Branch_Taken = 1'b1; ID_Branch_Tgt = 32'h0040_0080;
        #1;
        chk("pr_pcw", 32'(PC_Write), 32'd1);
        tick(); ID_Branch_Taken = 1'b0; #1;
        chk("pr_cnt", 32'(Stall_Count), 32'd5);
        reset = 1'b1; #1;
        chk("ar_epc", EPC, 32'h0);
        chk("ar_cnt", 32'(Stall_Count), 32'd0);
        chk("ar_pcw", 32'(PC_Write), 32'd1);
        tick(); reset = 1'b0; IMem_Ready = 1'b1; PC_Current = 32'h0040_0010; #1;
        chk("ar_npc", NewPC, 32'h0040_0014);
        chk("ar_flush", 32'(IF_ID_Flush), 32'd0);
        chk("ar_run", 32'(PC_Write), 32'd0);

        // PC+4 wraps
        PC_Current = 32'hFFFF_FFFC; #1;
        chk("wrap_npc", NewPC, 32'h0);

        // memory busy, no redirect: hold + flush, counter saturates
        IMem_Ready = 1'b0; #1;
        chk("busy_pcw", 32'(PC_Write), 32'd1);
        chk("busy_flush", 32'(IF_ID_Flush), 32'd1);
        chk("busy_ifw", 32'(IF_ID_Write), 32'd0);
        repeat (65534) tick();
        chk("sat_pre", 32'(Stall_Count), 32'h0000_FFFE);
        repeat (7) tick();
        chk("sat_cnt", 32'(Stall_Count), 32'h0000_FFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
